// File: rtl/amp_i2c_target.sv
// I2C target for the amp control port: START/STOP and address decode,
// then a pointer-based register write/read protocol on an 8-bit bank.
module amp_i2c_target #(
  parameter logic [6:0] I2C_ADDR = 7'h20,
  parameter bit         AUTO_INC = 1'b1
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       scl,
  input  logic       sdai,
  output logic       sdao,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic [3:0] status
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_REG,
    S_REG_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_t;

  logic [2:0] r_scl_q;
  logic [2:0] r_sda_q;

  state_t     r_state;
  logic [3:0] r_bitcnt;
  logic [7:0] r_shift;
  logic       r_rw;
  logic [7:0] r_ptr;
  logic       r_sdao;
  logic       r_wr_en;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;

  state_t     w_state_n;
  logic [3:0] w_bitcnt_n;
  logic [7:0] w_shift_n;
  logic       w_rw_n;
  logic [7:0] w_ptr_n;
  logic       w_sdao_n;
  logic       w_wr_en_n;
  logic [7:0] w_wr_addr_n;
  logic [7:0] w_wr_data_n;

  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_sda;
  logic [7:0] w_byte;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_scl_q <= 3'b111;
      r_sda_q <= 3'b111;
    end else begin
      r_scl_q <= {r_scl_q[1:0], scl};
      r_sda_q <= {r_sda_q[1:0], sdai};
    end
  end

  // bit [1] is the synchronised level, bit [2] its previous value
  assign w_sda      = r_sda_q[1];
  assign w_scl_rise = r_scl_q[1] & ~r_scl_q[2];
  assign w_scl_fall = ~r_scl_q[1] & r_scl_q[2];
  assign w_start    = r_scl_q[1] & r_scl_q[2] & ~r_sda_q[1] & r_sda_q[2];
  assign w_stop     = r_scl_q[1] & r_scl_q[2] & r_sda_q[1] & ~r_sda_q[2];
  assign w_byte     = {r_shift[6:0], w_sda};

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bitcnt  <= 4'd0;
      r_shift   <= 8'h00;
      r_rw      <= 1'b0;
      r_ptr     <= 8'h00;
      r_sdao    <= 1'b1;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 8'h00;
      r_wr_data <= 8'h00;
    end else begin
      r_state   <= w_state_n;
      r_bitcnt  <= w_bitcnt_n;
      r_shift   <= w_shift_n;
      r_rw      <= w_rw_n;
      r_ptr     <= w_ptr_n;
      r_sdao    <= w_sdao_n;
      r_wr_en   <= w_wr_en_n;
      r_wr_addr <= w_wr_addr_n;
      r_wr_data <= w_wr_data_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_bitcnt_n  = r_bitcnt;
    w_shift_n   = r_shift;
    w_rw_n      = r_rw;
    w_ptr_n     = r_ptr + {7'd0, r_wr_en & AUTO_INC};
    w_sdao_n    = r_sdao;
    w_wr_en_n   = 1'b0;
    w_wr_addr_n = r_wr_addr;
    w_wr_data_n = r_wr_data;

    if (w_start) begin
      w_state_n  = S_ADDR;
      w_bitcnt_n = 4'd0;
      w_sdao_n   = 1'b1;
    end else if (w_stop) begin
      w_state_n  = S_IDLE;
      w_bitcnt_n = 4'd0;
      w_sdao_n   = 1'b1;
    end else begin
      unique case (r_state)
        S_ADDR, S_REG, S_WDATA: begin
          if (w_scl_rise) begin
            w_shift_n  = w_byte;
            w_bitcnt_n = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              w_bitcnt_n = 4'd0;
              if (r_state == S_ADDR) begin
                if (w_byte[7:1] == I2C_ADDR) begin
                  w_state_n = S_ADDR_ACK;
                  w_rw_n    = w_byte[0];
                end else begin
                  w_state_n = S_IGNORE;
                end
              end else if (r_state == S_REG) begin
                w_ptr_n   = w_byte;
                w_state_n = S_REG_ACK;
              end else begin
                w_wr_en_n   = 1'b1;
                w_wr_addr_n = r_ptr;
                w_wr_data_n = w_byte;
                w_state_n   = S_WDATA_ACK;
              end
            end
          end
        end
        S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
          // first fall pulls ACK low, second fall ends the ACK slot
          if (w_scl_fall) begin
            if (r_bitcnt == 4'd0) begin
              w_sdao_n   = 1'b0;
              w_bitcnt_n = 4'd1;
            end else begin
              w_sdao_n   = 1'b1;
              w_bitcnt_n = 4'd0;
              if (r_state == S_ADDR_ACK && r_rw) begin
                w_state_n  = S_RDATA;
                w_shift_n  = {rd_data[6:0], 1'b0};
                w_sdao_n   = rd_data[7];
                w_bitcnt_n = 4'd1;
              end else if (r_state == S_ADDR_ACK) begin
                w_state_n = S_REG;
              end else begin
                w_state_n = S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          if (w_scl_fall) begin
            if (r_bitcnt == 4'd0) begin
              w_shift_n  = {rd_data[6:0], 1'b0};
              w_sdao_n   = rd_data[7];
              w_bitcnt_n = 4'd1;
            end else if (r_bitcnt == 4'd8) begin
              w_sdao_n   = 1'b1;
              w_bitcnt_n = 4'd0;
              w_state_n  = S_RDATA_ACK;
            end else begin
              w_sdao_n   = r_shift[7];
              w_shift_n  = {r_shift[6:0], 1'b0};
              w_bitcnt_n = r_bitcnt + 4'd1;
            end
          end
        end
        S_RDATA_ACK: begin
          if (w_scl_rise) begin
            w_ptr_n    = r_ptr + {7'd0, AUTO_INC};
            w_bitcnt_n = 4'd0;
            w_state_n  = w_sda ? S_IGNORE : S_RDATA;
          end
        end
        S_IDLE, S_IGNORE: begin
          w_sdao_n = 1'b1;
        end
        default: begin
          w_state_n = S_IDLE;
          w_sdao_n  = 1'b1;
        end
      endcase
    end
  end

  assign sdao    = r_sdao;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_addr = r_ptr;
  assign busy    = (r_state != S_IDLE);
  assign status  = r_state;

endmodule

// File: tb/tb_amp_i2c_target.sv
// Bench for amp_i2c_target: bit-level I2C controller, byte-level model,
// write scoreboard checked by an independent wr_en monitor.
module tb_amp_i2c_target;

  localparam int Q = 5;
  localparam logic [6:0] TADDR = 7'h20;
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_AACK = 4'd2;
  localparam logic [3:0] ST_IGN = 4'd9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic sdai;
  logic sdao;
  logic wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic busy;
  logic [3:0] status;

  logic [7:0] bank [256];
  logic [15:0] exp_q [$];
  logic [15:0] e_wr;
  logic [7:0] m_ptr;
  int n_chk = 0;
  int n_fail = 0;

  amp_i2c_target #(.I2C_ADDR(TADDR), .AUTO_INC(1'b1)) dut (
    .clk_in (clk),
    .reset  (rst),
    .scl    (m_scl),
    .sdai   (sdai),
    .sdao   (sdao),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy   (busy),
    .status (status)
  );

  always #5 clk = ~clk;

  // open-drain bus: controller and target wired-AND
  assign sdai = m_sda & sdao;
  assign rd_data = bank[rd_addr];

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr %h data %h, required no write",
                 wr_addr, wr_data);
      end else begin
        e_wr = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e_wr) begin
          n_fail++;
          $display("FAIL wr_strobe: got addr %h data %h, required addr %h data %h",
                   wr_addr, wr_data, e_wr[15:8], e_wr[7:0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic s);
    m_sda = b;
    wq();
    m_scl = 1'b1;
    wq();
    s = sdai;
    wq();
    m_scl = 1'b0;
    wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      b[i] = s;
    end
    send_bit(ack_bit, s);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wq();
    m_scl = 1'b1;
    wq();
    m_sda = 1'b0;
    wq();
    m_scl = 1'b0;
    wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wq();
    m_scl = 1'b1;
    wq();
    m_sda = 1'b1;
    wq();
    wq();
  endtask

  task automatic write_frame(input logic [7:0] rg, input logic [7:0] d[$],
                             input bit do_stop);
    logic a;
    i2c_start();
    send_byte({TADDR, 1'b0}, a);
    check("addr_w_ack", a, 0);
    send_byte(rg, a);
    check("reg_ack", a, 0);
    m_ptr = rg;
    foreach (d[k]) begin
      exp_q.push_back({m_ptr, d[k]});
      send_byte(d[k], a);
      check("data_ack", a, 0);
      m_ptr = m_ptr + 8'd1;
    end
    if (do_stop) begin
      i2c_stop();
      check("busy_after_stop", busy, 0);
      check("idle_after_stop", status, ST_IDLE);
      check("ptr_after_write", rd_addr, m_ptr);
    end
  endtask

  task automatic read_frame(input logic [7:0] rg, input int n);
    logic a;
    logic [7:0] got;
    logic [7:0] want;
    logic [7:0] none[$];
    none = {};
    write_frame(rg, none, 1'b0);
    i2c_start();
    send_byte({TADDR, 1'b1}, a);
    check("addr_r_ack", a, 0);
    for (int k = 0; k < n; k++) begin
      want = bank[m_ptr];
      recv_byte(k == n - 1, got);
      check("rd_byte", got, want);
      m_ptr = m_ptr + 8'd1;
    end
    check("ignore_after_nack", status, ST_IGN);
    check("ptr_after_read", rd_addr, m_ptr);
    i2c_stop();
    check("idle_after_read", status, ST_IDLE);
  endtask

  initial begin
    logic a;
    logic s;
    logic [7:0] dq[$];
    logic [7:0] rg;
    int n;

    for (int i = 0; i < 256; i++) bank[i] = 8'($urandom);
    bank[8'h35] = 8'h08;
    bank[8'h36] = 8'h5A;
    m_ptr = 8'h00;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_status", status, ST_IDLE);
    check("rst_sdao", sdao, 1);
    check("rst_busy", busy, 0);
    check("rst_ptr", rd_addr, 8'h00);
    check("rst_wr_en", wr_en, 0);

    dq = '{8'h18};
    write_frame(8'h40, dq, 1'b1);
    check("ptr_0x41", rd_addr, 8'h41);

    dq = '{8'hA1, 8'hA2, 8'hA3};
    write_frame(8'hFE, dq, 1'b1);
    check("ptr_wrap", rd_addr, 8'h01);

    i2c_start();
    send_byte(8'h42, a);
    check("wrong_addr_nack", a, 1);
    check("wrong_addr_ignore", status, ST_IGN);
    check("wrong_addr_busy", busy, 1);
    send_byte(8'h40, a);
    check("ignore_no_ack", a, 1);
    i2c_stop();
    dq = '{8'h5C};
    write_frame(8'h10, dq, 1'b1);

    read_frame(8'h35, 2);
    check("ptr_0x37", rd_addr, 8'h37);

    i2c_start();
    send_byte({TADDR, 1'b0}, a);
    send_byte(8'h22, a);
    m_ptr = 8'h22;
    for (int i = 0; i < 4; i++) send_bit(1'b1, s);
    i2c_stop();
    check("partial_idle", status, ST_IDLE);
    check("partial_sdao", sdao, 1);
    dq = '{8'h77, 8'h78};
    write_frame(8'h60, dq, 1'b1);

    for (int f = 0; f < 5; f++) begin
      rg = 8'($urandom);
      n = $urandom_range(1, 4);
      dq = {};
      for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
      write_frame(rg, dq, 1'b1);
    end
    for (int f = 0; f < 3; f++) begin
      rg = 8'($urandom);
      read_frame(rg, $urandom_range(1, 3));
    end

    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      rg = {TADDR, 1'b0};
      send_bit(rg[i], s);
    end
    check("ack_driven_low", sdao, 0);
    check("ack_state", status, ST_AACK);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_sdao", sdao, 1);
    check("mid_rst_status", status, ST_IDLE);
    check("mid_rst_ptr", rd_addr, 8'h00);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    m_ptr = 8'h00;
    m_scl = 1'b1;
    wq();
    m_sda = 1'b1;
    wq();
    dq = '{8'h3C};
    write_frame(8'h05, dq, 1'b1);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
